barrett_param_gen: RTL and testbench

//   Sequential precompute stage directly upstream of the Barrett reducer.

---
 rtl/barrett_param_gen.sv | 131 +++++++++++++
 tb/tb_barrett_param_gen.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/barrett_param_gen.sv
// rtl/barrett_param_gen.sv - Barrett reducer operand precompute (B, MU) via restoring divider
// Optional qH output enabled by defining BARRETT_PARAM_QH_EN.
module barrett_param_gen #(
    parameter int LOGQ    = 64,
    parameter int LOGQH   = 64,
    localparam int LOGLOGQ = $clog2(LOGQ + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LOGQ-1:0]    q_i,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [LOGQ:0]      MU,
`ifdef BARRETT_PARAM_QH_EN
    output logic [LOGQH-1:0]   qH,
`endif
    output logic [LOGLOGQ-1:0] B
);

    typedef enum logic [1:0] {
        st_idle,
        st_norm,
        st_div,
        st_done
    } state_t;

    state_t              state;
    logic [LOGQ-1:0]     q_lat;
    logic [LOGQ-1:0]     rem;
    logic [LOGQ:0]       quo;
    logic [LOGLOGQ-1:0]  k_reg;
    logic [LOGLOGQ:0]    cnt;
    logic                first;
    logic                err_pend;

    logic [LOGQ-1:0]     qm1;
    logic [LOGLOGQ-1:0]  k_comb;
    logic [LOGQ:0]       rem_sh;
    logic [LOGQ:0]       diff;
    logic                ge;

    always_comb begin
        qm1    = q_lat - LOGQ'(1);
        k_comb = '0;
        for (int i = 0; i < LOGQ; i++) begin
            if (qm1[i]) k_comb = LOGLOGQ'(i + 1);
        end
        // Remainder stays below q, so the shifted value is below 2q and the
        // sign of the (LOGQ+1)-bit difference is exactly the compare result.
        rem_sh = {rem, first};
        diff   = rem_sh - {1'b0, q_lat};
        ge     = ~diff[LOGQ];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= st_idle;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            MU       <= '0;
            B        <= '0;
`ifdef BARRETT_PARAM_QH_EN
            qH       <= '0;
`endif
            q_lat    <= '0;
            rem      <= '0;
            quo      <= '0;
            k_reg    <= '0;
            cnt      <= '0;
            first    <= 1'b0;
            err_pend <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                st_idle: begin
                    if (start) begin
                        q_lat <= q_i;
                        busy  <= 1'b1;
                        if (q_i < LOGQ'(2)) begin
                            err_pend <= 1'b1;
                            state    <= st_done;
                        end else begin
                            err_pend <= 1'b0;
                            state    <= st_norm;
                        end
                    end
                end
                st_norm: begin
                    k_reg <= k_comb;
                    rem   <= '0;
                    quo   <= '0;
                    cnt   <= {k_comb, 1'b0};
                    first <= 1'b1;
                    state <= st_div;
                end
                st_div: begin
                    rem   <= ge ? diff[LOGQ-1:0] : rem_sh[LOGQ-1:0];
                    quo   <= {quo[LOGQ-1:0], ge};
                    first <= 1'b0;
                    if (cnt == '0) state <= st_done;
                    else           cnt   <= cnt - 1'b1;
                end
                st_done: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= st_idle;
                    if (err_pend) begin
                        MU  <= '0;
                        B   <= '0;
                        err <= 1'b1;
`ifdef BARRETT_PARAM_QH_EN
                        qH  <= '0;
`endif
                    end else begin
                        MU  <= quo;
                        B   <= k_reg;
                        err <= 1'b0;
`ifdef BARRETT_PARAM_QH_EN
                        qH  <= LOGQH'(q_lat);
`endif
                    end
                end
                default: state <= st_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_barrett_param_gen.sv
// tb/tb_barrett_param_gen.sv - self-checking bench for barrett_param_gen
module tb_barrett_param_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] q_i;
    logic        busy, done, err;
    logic [64:0] MU;
    logic [6:0]  B;
`ifdef BARRETT_PARAM_QH_EN
    logic [63:0] qH;
`endif

    int total = 0;
    int bad   = 0;

    barrett_param_gen #(.LOGQ(64), .LOGQH(64)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .q_i   (q_i),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .MU    (MU),
`ifdef BARRETT_PARAM_QH_EN
        .qH    (qH),
`endif
        .B     (B)
    );

    always #5 clk = ~clk;

    function automatic int ref_b(input logic [63:0] q);
        logic [64:0] p;
        int b;
        p = 65'd1;
        b = 0;
        while (p < {1'b0, q}) begin
            p = p << 1;
            b++;
        end
        return b;
    endfunction

    function automatic logic [64:0] ref_mu(input logic [63:0] q, input int b);
        logic [129:0] num;
        logic [129:0] den;
        logic [129:0] quot;
        num  = 130'd1 << (2 * b);
        den  = {66'd0, q};
        quot = num / den;
        return quot[64:0];
    endfunction

    // Issue one op; lat = edges from the accepting edge until done is seen (300 = timeout)
    task automatic run_op(input logic [63:0] qv, output int lat);
        @(negedge clk);
        q_i   = qv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        q_i   = {$urandom, $urandom};
        lat   = 0;
        while (!done && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; q_i = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done, err, MU, B} !== '0) begin
            bad++;
            $display("FAIL reset busy=%b done=%b err=%b MU=%h B=%0d req all 0", busy, done, err, MU, B);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_known;
        logic [63:0] qs  [5] = '{64'd3, 64'd12289, 64'd8, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF};
        int          bs  [5] = '{2, 14, 3, 1, 64};
        logic [64:0] mus [5] = '{65'h5, 65'h5553, 65'h8, 65'h2, 65'h1_0000_0000_0000_0001};
        int          lts [5] = '{7, 31, 9, 5, 131};
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(qs[i], lat);
            total++;
            if (lat !== lts[i] || MU !== mus[i] || B !== 7'(bs[i]) || err !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL known q=%h lat=%0d MU=%h B=%0d err=%b busy=%b req lat=%0d MU=%h B=%0d err=0 busy=0",
                         qs[i], lat, MU, B, err, busy, lts[i], mus[i], bs[i]);
            end
`ifdef BARRETT_PARAM_QH_EN
            total++;
            if (qH !== qs[i]) begin
                bad++;
                $display("FAIL qh q=%h qH=%h", qs[i], qH);
            end
`endif
            repeat (6) begin
                @(posedge clk);
                #1;
                total++;
                if (MU !== mus[i] || B !== 7'(bs[i]) || done !== 1'b0) begin
                    bad++;
                    $display("FAIL hold q=%h MU=%h B=%0d done=%b req MU=%h B=%0d done=0", qs[i], MU, B, done, mus[i], bs[i]);
                end
            end
        end
    endtask

    task automatic test_err;
        logic [63:0] eq [2] = '{64'd0, 64'd1};
        int lat;
        for (int i = 0; i < 2; i++) begin
            run_op(64'd12289, lat);
            run_op(eq[i], lat);
            total++;
            if (lat !== 1 || err !== 1'b1 || MU !== '0 || B !== '0) begin
                bad++;
                $display("FAIL err q=%0d lat=%0d err=%b MU=%h B=%0d req lat=1 err=1 MU=0 B=0", eq[i], lat, err, MU, B);
            end
        end
        run_op(64'd3, lat);
        total++;
        if (err !== 1'b0 || MU !== 65'h5 || B !== 7'd2) begin
            bad++;
            $display("FAIL err_clear err=%b MU=%h B=%0d req err=0 MU=5 B=2", err, MU, B);
        end
    endtask

    task automatic test_random;
        logic [63:0] q;
        logic [64:0] emu;
        int eb, lat, elat;
        logic eerr;
        for (int n = 0; n < 24; n++) begin
            q = {$urandom, $urandom} >> $urandom_range(63, 0);
            eerr = (q < 64'd2);
            eb   = eerr ? 0 : ref_b(q);
            emu  = eerr ? '0 : ref_mu(q, eb);
            elat = eerr ? 1 : 2 * eb + 3;
            run_op(q, lat);
            total++;
            if (lat !== elat || MU !== emu || B !== 7'(eb) || err !== eerr) begin
                bad++;
                $display("FAIL random q=%h lat=%0d MU=%h B=%0d err=%b req lat=%0d MU=%h B=%0d err=%b",
                         q, lat, MU, B, err, elat, emu, eb, eerr);
            end
            if (!eerr) test_chain(q);
        end
    endtask

    // Barrett reduction with the published MU/B must land on C mod q
    task automatic test_chain(input logic [63:0] q);
        logic [255:0] c, r, t, qq;
        int fixes;
        qq = {192'd0, q};
        for (int j = 0; j < 3; j++) begin
            c = {128'd0, $urandom, $urandom, $urandom, $urandom} % (qq * qq);
            t = ((c >> (B - 1)) * {191'd0, MU}) >> (B + 1);
            r = c - t * qq;
            fixes = 0;
            while (r >= qq && fixes < 3) begin
                r = r - qq;
                fixes++;
            end
            total++;
            if (r !== c % qq || fixes > 2) begin
                bad++;
                $display("FAIL chain q=%h c=%h r=%h fixes=%0d req r=%h fixes<=2", q, c, r, fixes, c % qq);
            end
        end
    endtask

    task automatic test_busy_ignore;
        int lat, extra;
        @(negedge clk);
        q_i = 64'd12289; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 300) begin
            @(negedge clk);
            start = (lat % 3 == 1);
            q_i   = 64'd3;
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        total++;
        if (lat !== 31 || MU !== 65'h5553 || B !== 7'd14) begin
            bad++;
            $display("FAIL busy_ignore lat=%0d MU=%h B=%0d req lat=31 MU=5553 B=14", lat, MU, B);
        end
        extra = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL no_queue busy_or_done_cycles=%0d req 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        int first_done, second_done, ndone, guard;
        @(negedge clk);
        q_i = 64'd3; start = 1'b1;
        @(posedge clk);
        #1;
        first_done = -1; second_done = -1; ndone = 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = e;
                else if (second_done < 0) second_done = e;
            end
        end
        start = 1'b0;
        total++;
        if (ndone !== 2 || first_done !== 7 || second_done !== 15 || MU !== 65'h5) begin
            bad++;
            $display("FAIL back_to_back n=%0d first=%0d second=%0d MU=%h req n=2 first=7 second=15 MU=5",
                     ndone, first_done, second_done, MU);
        end
        guard = 0;
        while (busy && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL drain busy=%b req 0", busy);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_midreset;
        int lat, seen;
        @(negedge clk);
        q_i = 64'hFFFF_FFFF_FFFF_FFFF; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({busy, done, err, MU, B} !== '0) begin
            bad++;
            $display("FAIL midreset busy=%b done=%b err=%b MU=%h B=%0d req all 0", busy, done, err, MU, B);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (140) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL post_reset_idle active_cycles=%0d req 0", seen);
        end
        run_op(64'd12289, lat);
        total++;
        if (lat !== 31 || MU !== 65'h5553 || B !== 7'd14) begin
            bad++;
            $display("FAIL post_reset_op lat=%0d MU=%h B=%0d req lat=31 MU=5553 B=14", lat, MU, B);
        end
    endtask

    initial begin
        test_reset;
        test_known;
        test_err;
        test_random;
        test_busy_ignore;
        test_back_to_back;
        test_midreset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
